// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one external combinational ALU between two
// valid/ready requesters; results return on a single registered response channel.
module alu_arbiter #(
    parameter int DATA_W = 32,
    parameter int OP_W   = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [1:0]        req_valid,
    output logic [1:0]        req_ready,
    input  logic [OP_W-1:0]   req0_op_code,
    input  logic [OP_W-1:0]   req1_op_code,
    input  logic [DATA_W-1:0] req0_operand1,
    input  logic [DATA_W-1:0] req1_operand1,
    input  logic [DATA_W-1:0] req0_operand2,
    input  logic [DATA_W-1:0] req1_operand2,
    output logic [OP_W-1:0]   alu_op_code,
    output logic [DATA_W-1:0] alu_operand1,
    output logic [DATA_W-1:0] alu_operand2,
    input  logic [DATA_W-1:0] alu_result,
    input  logic              alu_zero,
    input  logic              alu_overflow,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_id,
    output logic [DATA_W-1:0] rsp_result,
    output logic              rsp_zero,
    output logic              rsp_overflow,
    output logic              rsp_err,
    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        RESP
    } state_t;

    state_t            state;
    logic              ptr;
    logic              legal_q;
    logic [1:0]        grant;
    logic              gnt_id;
    logic [OP_W-1:0]   sel_op;
    logic [DATA_W-1:0] sel_a;
    logic [DATA_W-1:0] sel_b;

    // Legal encodings: 100000..100110 and 000001..000011
    function automatic logic legal_op(input logic [OP_W-1:0] op);
        return ((op >= OP_W'(32)) && (op <= OP_W'(38))) ||
               ((op >= OP_W'(1))  && (op <= OP_W'(3)));
    endfunction

    // Grant is gated by rst_n so req_ready stays low while reset is held.
    always_comb begin
        grant  = '0;
        gnt_id = 1'b0;
        if (state == IDLE && rst_n) begin
            case (req_valid)
                2'b01: begin grant = 2'b01; gnt_id = 1'b0; end
                2'b10: begin grant = 2'b10; gnt_id = 1'b1; end
                2'b11: begin grant = ptr ? 2'b10 : 2'b01; gnt_id = ptr; end
                default: begin grant = '0; gnt_id = 1'b0; end
            endcase
        end
    end

    always_comb begin
        sel_op = gnt_id ? req1_op_code  : req0_op_code;
        sel_a  = gnt_id ? req1_operand1 : req0_operand1;
        sel_b  = gnt_id ? req1_operand2 : req0_operand2;
    end

    assign req_ready = grant;
    assign busy      = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            ptr          <= 1'b0;
            legal_q      <= 1'b0;
            alu_op_code  <= '0;
            alu_operand1 <= '0;
            alu_operand2 <= '0;
            rsp_valid    <= 1'b0;
            rsp_id       <= 1'b0;
            rsp_result   <= '0;
            rsp_zero     <= 1'b0;
            rsp_overflow <= 1'b0;
            rsp_err      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (|grant) begin
                        alu_op_code  <= sel_op;
                        alu_operand1 <= sel_a;
                        alu_operand2 <= sel_b;
                        rsp_id       <= gnt_id;
                        legal_q      <= legal_op(sel_op);
                        ptr          <= ~gnt_id;
                        state        <= EXEC;
                    end
                end
                EXEC: begin
                    rsp_valid <= 1'b1;
                    if (legal_q) begin
                        rsp_result   <= alu_result;
                        rsp_zero     <= alu_zero;
                        rsp_overflow <= alu_overflow;
                        rsp_err      <= 1'b0;
                    end else begin
                        rsp_result   <= '0;
                        rsp_zero     <= 1'b0;
                        rsp_overflow <= 1'b0;
                        rsp_err      <= 1'b1;
                    end
                    state <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed-vector bench for alu_arbiter; a small behavioural ALU closes the loop.
module tb_alu_arbiter;

    localparam int DATA_W = 32;
    localparam int OP_W   = 6;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [1:0]        req_valid = '0;
    logic [1:0]        req_ready;
    logic [OP_W-1:0]   req0_op_code = '0, req1_op_code = '0;
    logic [DATA_W-1:0] req0_operand1 = '0, req1_operand1 = '0;
    logic [DATA_W-1:0] req0_operand2 = '0, req1_operand2 = '0;
    logic [OP_W-1:0]   alu_op_code;
    logic [DATA_W-1:0] alu_operand1, alu_operand2;
    logic [DATA_W-1:0] alu_result;
    logic              alu_zero, alu_overflow;
    logic              rsp_valid;
    logic              rsp_ready = 1'b1;
    logic              rsp_id;
    logic [DATA_W-1:0] rsp_result;
    logic              rsp_zero, rsp_overflow, rsp_err, busy;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    alu_arbiter #(.DATA_W(DATA_W), .OP_W(OP_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req0_op_code(req0_op_code), .req1_op_code(req1_op_code),
        .req0_operand1(req0_operand1), .req1_operand1(req1_operand1),
        .req0_operand2(req0_operand2), .req1_operand2(req1_operand2),
        .alu_op_code(alu_op_code), .alu_operand1(alu_operand1), .alu_operand2(alu_operand2),
        .alu_result(alu_result), .alu_zero(alu_zero), .alu_overflow(alu_overflow),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_result(rsp_result), .rsp_zero(rsp_zero), .rsp_overflow(rsp_overflow),
        .rsp_err(rsp_err), .busy(busy)
    );

    // Illegal codes return garbage so that masking in the arbiter is observable.
    always_comb begin
        alu_overflow = 1'b0;
        case (alu_op_code)
            6'b100000: begin
                alu_result   = alu_operand1 + alu_operand2;
                alu_overflow = (alu_operand1[31] == alu_operand2[31]) && (alu_result[31] != alu_operand1[31]);
            end
            6'b100010: begin
                alu_result   = alu_operand1 - alu_operand2;
                alu_overflow = (alu_operand1[31] != alu_operand2[31]) && (alu_result[31] != alu_operand1[31]);
            end
            6'b100100: alu_result = alu_operand1 & alu_operand2;
            6'b100101: alu_result = alu_operand1 | alu_operand2;
            6'b100110: alu_result = alu_operand1 ^ alu_operand2;
            6'b000001: alu_result = alu_operand1 << alu_operand2[4:0];
            6'b000010: alu_result = alu_operand1 >> alu_operand2[4:0];
            6'b000011: alu_result = $signed(alu_operand1) >>> alu_operand2[4:0];
            default: begin
                alu_result   = 32'hDEADBEEF;
                alu_overflow = 1'b1;
            end
        endcase
        alu_zero = (alu_op_code == 6'b111111) ? 1'b1 : (alu_result == '0);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic set_req(input int id, input logic [5:0] op, input logic [31:0] a, input logic [31:0] b);
        if (id == 0) begin
            req0_op_code = op; req0_operand1 = a; req0_operand2 = b;
        end else begin
            req1_op_code = op; req1_operand1 = a; req1_operand2 = b;
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst_n = 1'b0;
        #3;
        rst_n = 1'b1;
        tick();
    endtask

    // Entered at posedge+1 in IDLE with rsp_ready high; leaves at posedge+1 back in IDLE.
    task automatic run_op(input logic [1:0] valid, input logic [1:0] exp_gnt,
                          input logic [5:0] eop, input logic [31:0] ea, input logic [31:0] eb,
                          input logic [31:0] eres, input logic ez, input logic eo, input logic ee);
        req_valid = valid;
        #1;
        check("grant", req_ready, exp_gnt);
        tick();
        check("exec_busy", busy, 1);
        check("exec_req_ready", req_ready, 0);
        check("exec_op", alu_op_code, eop);
        check("exec_operand1", alu_operand1, ea);
        check("exec_operand2", alu_operand2, eb);
        check("exec_rsp_valid", rsp_valid, 0);
        tick();
        check("rsp_valid", rsp_valid, 1);
        check("rsp_id", rsp_id, exp_gnt[1]);
        check("rsp_result", rsp_result, eres);
        check("rsp_zero", rsp_zero, ez);
        check("rsp_overflow", rsp_overflow, eo);
        check("rsp_err", rsp_err, ee);
        tick();
        check("idle_busy", busy, 0);
        check("idle_rsp_valid", rsp_valid, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        #2;
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_req_ready", req_ready, 0);
        check("rst_rsp_id", rsp_id, 0);
        check("rst_rsp_result", rsp_result, 0);
        check("rst_rsp_flags", {rsp_zero, rsp_overflow, rsp_err}, 0);
        check("rst_alu_op", alu_op_code, 0);
        check("rst_alu_operands", alu_operand1 | alu_operand2, 0);
        #20;
        rst_n = 1'b1;
        tick();

        // single add
        set_req(0, 6'b100000, 100, 45);
        run_op(2'b01, 2'b01, 6'b100000, 100, 45, 145, 0, 0, 0);
        req_valid = '0;

        // contention from reset: 0,1,0,1
        do_reset();
        set_req(0, 6'b100010, 100, 45);
        set_req(1, 6'b100100, 100, 45);
        for (int i = 0; i < 4; i++) begin
            if (i % 2 == 0)
                run_op(2'b11, 2'b01, 6'b100010, 100, 45, 55, 0, 0, 0);
            else
                run_op(2'b11, 2'b10, 6'b100100, 100, 45, 36, 0, 0, 0);
        end
        req_valid = '0;

        // zero flag with five cycles of backpressure; other requests must wait
        set_req(1, 6'b100010, 45, 45);
        rsp_ready = 1'b0;
        req_valid = 2'b10;
        #1;
        check("bp_grant", req_ready, 2'b10);
        tick();
        req_valid = 2'b11;
        tick();
        for (int i = 0; i < 5; i++) begin
            check("bp_rsp_valid", rsp_valid, 1);
            check("bp_rsp_result", rsp_result, 0);
            check("bp_rsp_zero", rsp_zero, 1);
            check("bp_rsp_ovf_err", {rsp_overflow, rsp_err}, 0);
            check("bp_rsp_id", rsp_id, 1);
            check("bp_req_ready", req_ready, 0);
            check("bp_busy", busy, 1);
            tick();
        end
        req_valid = '0;
        rsp_ready = 1'b1;
        #1;
        check("bp_rsp_valid_hs", rsp_valid, 1);
        tick();
        check("bp_idle_busy", busy, 0);
        check("bp_idle_rsp_valid", rsp_valid, 0);

        // shift and xor
        set_req(0, 6'b000001, 1, 4);
        run_op(2'b01, 2'b01, 6'b000001, 1, 4, 16, 0, 0, 0);
        set_req(1, 6'b100110, 100, 45);
        run_op(2'b10, 2'b10, 6'b100110, 100, 45, 73, 0, 0, 0);

        // signed overflow on add
        set_req(0, 6'b100000, 32'h7FFFFFFF, 1);
        run_op(2'b01, 2'b01, 6'b100000, 32'h7FFFFFFF, 1, 32'h80000000, 0, 1, 0);

        // illegal op, then a legal one clears the error
        set_req(0, 6'b111111, 7, 8);
        run_op(2'b01, 2'b01, 6'b111111, 7, 8, 0, 0, 0, 1);
        set_req(1, 6'b100000, 7, 8);
        run_op(2'b10, 2'b10, 6'b100000, 7, 8, 15, 0, 0, 0);
        set_req(0, 6'b100111, 7, 8);
        run_op(2'b01, 2'b01, 6'b100111, 7, 8, 0, 0, 0, 1);
        req_valid = '0;

        // reset in EXEC
        set_req(0, 6'b100000, 1, 2);
        req_valid = 2'b01;
        tick();
        check("mid_exec_busy_pre", busy, 1);
        rst_n = 1'b0;
        #1;
        check("mid_exec_busy", busy, 0);
        check("mid_exec_rsp_valid", rsp_valid, 0);
        check("mid_exec_req_ready", req_ready, 0);
        #1;
        rst_n = 1'b1;
        req_valid = '0;
        tick();

        // reset in RESP, after a req0 grant moved the pointer to 1
        rsp_ready = 1'b0;
        req_valid = 2'b01;
        tick();
        req_valid = '0;
        tick();
        check("mid_resp_rsp_valid_pre", rsp_valid, 1);
        check("mid_resp_result_pre", rsp_result, 3);
        rst_n = 1'b0;
        #1;
        check("mid_resp_rsp_valid", rsp_valid, 0);
        check("mid_resp_busy", busy, 0);
        check("mid_resp_result", rsp_result, 0);
        #1;
        rst_n = 1'b1;
        rsp_ready = 1'b1;
        tick();

        // pointer back at requester 0
        set_req(0, 6'b100010, 100, 45);
        set_req(1, 6'b100100, 100, 45);
        run_op(2'b11, 2'b01, 6'b100010, 100, 45, 55, 0, 0, 0);
        run_op(2'b11, 2'b10, 6'b100100, 100, 45, 36, 0, 0, 0);
        req_valid = '0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
